// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory: one-cycle fetch with stall/flush, write-first load port.
// Define IMEM_BOUNDS_CHECK_EN to flag misaligned/out-of-range fetches and drop such loads.
module inst_mem_sync #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned IDX_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  input  logic                  fetch_stall,
  input  logic                  fetch_flush,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_inst,
  output logic                  fetch_err,
  input  logic                  load_en,
  input  logic [31:0]           load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [IDX_WIDTH:0]    load_count
);

  localparam int unsigned CntW = IDX_WIDTH + 1;

  // Zero image at time zero; reset deliberately leaves the program in place.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [IDX_WIDTH-1:0]  fetch_raw, load_raw;
  logic [IDX_WIDTH-1:0]  fetch_idx, load_idx;
  logic                  fetch_bad, load_bad;
  logic                  load_ok, bypass;
  logic [DATA_WIDTH-1:0] fetch_word;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       count_q, count_d;

  assign fetch_raw = fetch_addr[IDX_WIDTH+1:2];
  assign load_raw  = load_addr[IDX_WIDTH+1:2];
  assign fetch_idx = IDX_WIDTH'(fetch_raw % DEPTH);
  assign load_idx  = IDX_WIDTH'(load_raw % DEPTH);

`ifdef IMEM_BOUNDS_CHECK_EN
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (32'(fetch_raw) >= DEPTH) ||
                     (fetch_addr[31:IDX_WIDTH+2] != '0);
  assign load_bad  = (load_addr[1:0] != 2'b00) || (32'(load_raw) >= DEPTH) ||
                     (load_addr[31:IDX_WIDTH+2] != '0);
`else
  logic unused_addr;
  assign unused_addr = ^{fetch_addr[1:0], fetch_addr[31:IDX_WIDTH+2],
                         load_addr[1:0], load_addr[31:IDX_WIDTH+2]};
  assign fetch_bad   = 1'b0;
  assign load_bad    = 1'b0;
`endif

  assign load_ok    = load_en && !reset && !load_bad;
  // Write-first: a fetch of the word being loaded this cycle sees the new data.
  assign bypass     = load_ok && (load_idx == fetch_idx);
  assign fetch_word = bypass ? load_data : mem[fetch_idx];

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    err_d   = err_q;
    count_d = count_q;
    if (fetch_flush) begin
      valid_d = 1'b0;
      inst_d  = '0;
      err_d   = 1'b0;
    end else if (!fetch_stall) begin
      if (fetch_req) begin
        valid_d = 1'b1;
        err_d   = fetch_bad;
        inst_d  = fetch_bad ? '0 : fetch_word;
      end else begin
        valid_d = 1'b0;
      end
    end
    if (load_ok && (count_q != '1)) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

  assign fetch_valid = valid_q;
  assign fetch_inst  = inst_q;
  assign fetch_err   = err_q;
  assign load_count  = count_q;

endmodule

// File: doc/inst_mem_sync.md
INST_MEM_SYNC -- requirements
Module: inst_mem_sync

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_WIDTH, 32, instruction word width in bits
  DEPTH, 512, number of instruction words stored
  IDX_WIDTH, 9, word-index width; SHALL satisfy 2^IDX_WIDTH >= DEPTH
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all state updates on rising edge
  reset  input  1  synchronous, active-high reset
  fetch_req  input  1  fetch request this cycle
  fetch_addr  input  32  byte address of requested instruction
  fetch_stall  input  1  hold current output, ignore fetch_req
  fetch_flush  input  1  discard current output
  fetch_valid  output  1  fetch_inst/fetch_err are valid
  fetch_inst  output  DATA_WIDTH  fetched instruction word
  fetch_err  output  1  misaligned or out-of-range fetch
  load_en  input  1  write one word into memory this cycle
  load_addr  input  32  byte address of word to write
  load_data  input  DATA_WIDTH  word to write
  load_count  output  IDX_WIDTH+1  words written since reset, saturating
REQ-003 The block SHALL use one clock domain (clk); reset SHALL be synchronous and active-high.

Function
REQ-004 Word index SHALL be addr[IDX_WIDTH+1:2]; addr[1:0] are the alignment bits.
REQ-005 Read latency SHALL be exactly one cycle: fetch_req=1 in cycle N, stall=0, flush=0 -> fetch_valid=1 and fetch_inst=mem[index] in cycle N+1.
REQ-006 fetch_req=0, stall=0, flush=0 SHALL drive fetch_valid=0 next cycle; fetch_inst SHALL keep its previous value.
REQ-007 fetch_stall=1 SHALL hold fetch_valid, fetch_inst and fetch_err unchanged and ignore fetch_req.
REQ-008 fetch_flush=1 SHALL take priority over fetch_stall and fetch_req: next cycle fetch_valid=0, fetch_err=0, fetch_inst=0.
REQ-009 load_en=1 SHALL write load_data to mem[load index] at the clock edge, independent of stall/flush.
REQ-010 Simultaneous load_en and fetch_req to the same word SHALL return the new load_data (write-first bypass).
REQ-011 load_count SHALL increment by 1 per accepted write and saturate at 2^(IDX_WIDTH+1)-1.
REQ-012 A load with misaligned or out-of-range address (when bounds checking is compiled in) SHALL be dropped and SHALL NOT increment load_count.
REQ-013 Memory contents SHALL initialise to all zeros at time zero.

Reset
REQ-014 reset=1 SHALL force next cycle: fetch_valid=0, fetch_inst=0, fetch_err=0, load_count=0.
REQ-015 reset SHALL NOT clear memory contents; a program loaded before reset SHALL remain fetchable after it.
REQ-016 reset SHALL override fetch_req, fetch_stall, fetch_flush and load_en in the same cycle (no write occurs).
REQ-017 A reset asserted during a stall SHALL discard the held output.

Configuration
REQ-018 Macro IMEM_BOUNDS_CHECK_EN SHALL select address checking.
REQ-019 With IMEM_BOUNDS_CHECK_EN defined: a fetch with addr[1:0]!=0 or index>=DEPTH or addr[31:IDX_WIDTH+2]!=0 SHALL return fetch_valid=1, fetch_err=1, fetch_inst=0 (NOP).
REQ-020 Without IMEM_BOUNDS_CHECK_EN: addr[1:0] and upper bits SHALL be ignored, index SHALL wrap modulo DEPTH, fetch_err SHALL be constant 0, and no load SHALL be dropped.

Verification
REQ-021 Load 0x20040020 at 0x0, 0x1000ffff at 0x4; fetch 0x4 -> next cycle valid=1, inst=0x1000ffff, err=0; load_count=2.
REQ-022 Fetch 0x8 in cycle N, stall=1 in N+1..N+3 with fetch_req=1 at 0x0 -> inst stays mem[2] through N+4; 0x20040020 only after stall drops.
REQ-023 Same cycle load_en to 0x10 with 0xDEADBEEF and fetch 0x10 -> next cycle inst=0xDEADBEEF.
REQ-024 With IMEM_BOUNDS_CHECK_EN: fetch 0x6 -> valid=1, err=1, inst=0; fetch 0x800 (DEPTH=512) -> err=1; load to 0x802 -> load_count unchanged.
REQ-025 Stall=1 and flush=1 together -> next cycle valid=0, inst=0; reset mid-stall -> valid=0, load_count=0, then fetch 0x0 still returns previously loaded 0x20040020.
REQ-026 Without IMEM_BOUNDS_CHECK_EN, DEPTH=512: fetch 0x804 -> inst=mem[1], err=0.
